// File: rtl/sparc_glue_pkg.sv
// Shared constants for the SPARC register-file write glue: FSM encoding,
// write-port identifiers and the hardwired-zero register address.
package sparc_glue_pkg;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_WRITE = 1'b1;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    localparam logic [4:0] REG_G0 = 5'b00000;

endpackage

// File: rtl/rr_pick_2.sv
// Two-way round-robin pick: a lone requester wins, and on a tie the port
// that was not granted last wins.
module rr_pick_2
    import sparc_glue_pkg::*;
(
    input  logic i_req_a,
    input  logic i_req_b,
    input  logic i_last,
    output logic o_gnt_valid,
    output logic o_gnt_port
);

    always_comb begin
        o_gnt_valid = i_req_a | i_req_b;
        o_gnt_port  = PORT_A;
        if (i_req_a && i_req_b) begin
            o_gnt_port = (i_last == PORT_A) ? PORT_B : PORT_A;
        end else if (i_req_b) begin
            o_gnt_port = PORT_B;
        end
    end

endmodule

// File: rtl/regfile_write_sched.sv
// Register-file write-port scheduler: arbitrates ALU (A) and load (B)
// writebacks onto the single decoder/write-data path, one write per 2 cycles.
module regfile_write_sched
    import sparc_glue_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              ReqA,
    input  logic [ADDR_W-1:0] AddrA,
    input  logic [DATA_W-1:0] DataA,
    output logic              AckA,
    input  logic              ReqB,
    input  logic [ADDR_W-1:0] AddrB,
    input  logic [DATA_W-1:0] DataB,
    output logic              AckB,
    output logic [ADDR_W-1:0] DecIn,
    output logic              DecLd,
    output logic [DATA_W-1:0] WrData,
    output logic              Busy
);

    // Handshake: ReqX is a level held until AckX; AckX is a one-cycle pulse
    // coinciding with the WRITE cycle, and the requester must drop ReqX (or
    // present a new transaction) at the edge that ends that pulse.

    logic              r_state;
    logic              r_last;
    logic              r_ack_a;
    logic              r_ack_b;
    logic              r_dec_ld;
    logic [ADDR_W-1:0] r_dec_in;
    logic [DATA_W-1:0] r_wr_data;

    logic              w_state_nxt;
    logic              w_last_nxt;
    logic              w_ack_a_nxt;
    logic              w_ack_b_nxt;
    logic              w_dec_ld_nxt;
    logic [ADDR_W-1:0] w_dec_in_nxt;
    logic [DATA_W-1:0] w_wr_data_nxt;
    logic              w_gnt_valid;
    logic              w_gnt_port;
    logic              w_grant;

    rr_pick_2 u_pick (
        .i_req_a     (ReqA),
        .i_req_b     (ReqB),
        .i_last      (r_last),
        .o_gnt_valid (w_gnt_valid),
        .o_gnt_port  (w_gnt_port)
    );

    assign w_grant = (r_state == ST_IDLE) && w_gnt_valid;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state   <= ST_IDLE;
            r_last    <= PORT_B;
            r_ack_a   <= 1'b0;
            r_ack_b   <= 1'b0;
            r_dec_ld  <= 1'b0;
            r_dec_in  <= '0;
            r_wr_data <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_last    <= w_last_nxt;
            r_ack_a   <= w_ack_a_nxt;
            r_ack_b   <= w_ack_b_nxt;
            r_dec_ld  <= w_dec_ld_nxt;
            r_dec_in  <= w_dec_in_nxt;
            r_wr_data <= w_wr_data_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  w_state_nxt = w_gnt_valid ? ST_WRITE : ST_IDLE;
            ST_WRITE: w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Destination and data hold their last values outside a grant so the
    // decoder input does not toggle needlessly.
    always_comb begin
        w_last_nxt    = r_last;
        w_ack_a_nxt   = 1'b0;
        w_ack_b_nxt   = 1'b0;
        w_dec_ld_nxt  = 1'b0;
        w_dec_in_nxt  = r_dec_in;
        w_wr_data_nxt = r_wr_data;
        if (w_grant) begin
            w_last_nxt = w_gnt_port;
            if (w_gnt_port == PORT_A) begin
                w_ack_a_nxt   = 1'b1;
                w_dec_in_nxt  = AddrA;
                w_wr_data_nxt = DataA;
            end else begin
                w_ack_b_nxt   = 1'b1;
                w_dec_in_nxt  = AddrB;
                w_wr_data_nxt = DataB;
            end
            // %g0 is hardwired zero: acknowledge but never strobe the decoder.
            w_dec_ld_nxt = (w_dec_in_nxt != ADDR_W'(REG_G0));
        end
    end

    assign AckA   = r_ack_a;
    assign AckB   = r_ack_b;
    assign DecLd  = r_dec_ld;
    assign DecIn  = r_dec_in;
    assign WrData = r_wr_data;
    assign Busy   = (r_state == ST_WRITE);

endmodule

// File: tb/tb_regfile_write_sched.sv
// Self-checking bench for regfile_write_sched: directed cases plus random
// traffic against a cycle-level reference model and a write scoreboard.
module tb_regfile_write_sched;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_a, req_b;
    logic [ADDR_W-1:0] addr_a, addr_b;
    logic [DATA_W-1:0] data_a, data_b;
    logic              ack_a, ack_b, dec_ld, busy;
    logic [ADDR_W-1:0] dec_in;
    logic [DATA_W-1:0] wr_data;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: what the write path should show after each edge.
    bit                m_busy;
    int                m_last_served;   // 0 = A, 1 = B
    bit                m_ack_a, m_ack_b, m_dec_ld;
    logic [ADDR_W-1:0] m_dec_in;
    logic [DATA_W-1:0] m_wr_data;
    logic [ADDR_W+DATA_W-1:0] exp_q[$];

    regfile_write_sched #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .Clk    (clk),
        .Reset  (rst),
        .ReqA   (req_a),
        .AddrA  (addr_a),
        .DataA  (data_a),
        .AckA   (ack_a),
        .ReqB   (req_b),
        .AddrB  (addr_b),
        .DataB  (data_b),
        .AckB   (ack_b),
        .DecIn  (dec_in),
        .DecLd  (dec_ld),
        .WrData (wr_data),
        .Busy   (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy        = 1'b0;
        m_last_served = 1;
        m_ack_a       = 1'b0;
        m_ack_b       = 1'b0;
        m_dec_ld      = 1'b0;
        m_dec_in      = '0;
        m_wr_data     = '0;
    endtask

    // One rising edge: a write takes two cycles, requests seen during the
    // second are ignored, and ties go to whoever was not served last.
    task automatic model_edge();
        int winner;
        m_ack_a  = 1'b0;
        m_ack_b  = 1'b0;
        m_dec_ld = 1'b0;
        if (m_busy) begin
            m_busy = 1'b0;
        end else if (req_a || req_b) begin
            if (req_a && req_b) winner = 1 - m_last_served;
            else                winner = req_a ? 0 : 1;
            m_last_served = winner;
            m_busy        = 1'b1;
            m_dec_in      = (winner == 0) ? addr_a : addr_b;
            m_wr_data     = (winner == 0) ? data_a : data_b;
            if (winner == 0) m_ack_a = 1'b1;
            else             m_ack_b = 1'b1;
            m_dec_ld = (m_dec_in != 0);
            if (m_dec_ld) exp_q.push_back({m_dec_in, m_wr_data});
        end
    endtask

    task automatic check_outputs();
        logic [ADDR_W+DATA_W-1:0] e;
        chk("ack_a",   64'(ack_a),   64'(m_ack_a));
        chk("ack_b",   64'(ack_b),   64'(m_ack_b));
        chk("dec_ld",  64'(dec_ld),  64'(m_dec_ld));
        chk("busy",    64'(busy),    64'(m_busy));
        chk("dec_in",  64'(dec_in),  64'(m_dec_in));
        chk("wr_data", 64'(wr_data), 64'(m_wr_data));
        if (dec_ld === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_write", 64'(dec_ld), 64'(0));
            end else begin
                e = exp_q.pop_front();
                chk("sb_write", 64'({dec_in, wr_data}), 64'(e));
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    // Async reset asserted away from the edge; outputs must clear at once.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic drive_a(input logic r, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        req_a = r; addr_a = a; data_a = d;
    endtask

    task automatic drive_b(input logic r, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        req_b = r; addr_b = a; data_b = d;
    endtask

    function automatic logic [ADDR_W-1:0] rand_addr();
        return ($urandom_range(0, 5) == 0) ? '0 : ADDR_W'($urandom_range(0, 31));
    endfunction

    initial begin
        int grants[$];
        int cnt, consec;
        bit prev_ld;

        rst = 1'b1;
        drive_a(1'b0, '0, '0);
        drive_b(1'b0, '0, '0);
        do_reset();
        repeat (3) step();
        chk("idle_no_ld", 64'(dec_ld), 64'(0));

        // Single A request.
        drive_a(1'b1, 5'd7, 32'hDEADBEEF);
        step();
        chk("a_decin",  64'(dec_in),  64'(7));
        chk("a_ld",     64'(dec_ld),  64'(1));
        chk("a_data",   64'(wr_data), 64'(32'hDEADBEEF));
        chk("a_ack",    64'(ack_a),   64'(1));
        chk("a_busy",   64'(busy),    64'(1));
        drive_a(1'b0, 5'd7, 32'hDEADBEEF);
        step();
        chk("a_end_ack",  64'(ack_a),  64'(0));
        chk("a_end_busy", 64'(busy),   64'(0));
        chk("a_hold_in",  64'(dec_in), 64'(7));
        step();

        // Tie after reset: A first, B two cycles later, then alternation.
        do_reset();
        drive_a(1'b1, 5'd3, 32'h0000_0A03);
        drive_b(1'b1, 5'd9, 32'h0000_0B09);
        step();
        chk("tie_first_a", 64'(ack_a),  64'(1));
        chk("tie_first_in", 64'(dec_in), 64'(3));
        drive_a(1'b0, 5'd3, 32'h0000_0A03);
        step();
        step();
        chk("tie_then_b",  64'(ack_b),  64'(1));
        chk("tie_then_in", 64'(dec_in), 64'(9));
        drive_a(1'b1, 5'd3, 32'h0000_0A03);
        for (int i = 0; i < 8; i++) begin
            step();
            if (ack_a === 1'b1) grants.push_back(0);
            if (ack_b === 1'b1) grants.push_back(1);
        end
        chk("alt_count", 64'(grants.size()), 64'(4));
        for (int i = 0; i < grants.size() && i < 4; i++)
            chk("alt_order", 64'(grants[i]), 64'(i % 2));
        drive_a(1'b0, '0, '0);
        drive_b(1'b0, '0, '0);
        step();
        step();

        // %g0 write: acknowledged, never loaded.
        drive_b(1'b1, 5'd0, 32'h12345678);
        step();
        chk("g0_ack",  64'(ack_b),   64'(1));
        chk("g0_busy", 64'(busy),    64'(1));
        chk("g0_ld",   64'(dec_ld),  64'(0));
        chk("g0_data", 64'(wr_data), 64'(32'h12345678));
        drive_b(1'b0, 5'd0, 32'h12345678);
        step();
        chk("g0_ld_after", 64'(dec_ld), 64'(0));

        // Reset during A's WRITE cycle, request held through reset.
        drive_a(1'b1, 5'd5, 32'hCAFE0005);
        step();
        chk("rstw_pre_ld", 64'(dec_ld), 64'(1));
        do_reset();
        chk("rstw_ld",  64'(dec_ld), 64'(0));
        chk("rstw_ack", 64'(ack_a),  64'(0));
        step();
        chk("rstw_reack", 64'(ack_a),  64'(1));
        chk("rstw_rein",  64'(dec_in), 64'(5));
        chk("rstw_reld",  64'(dec_ld), 64'(1));
        drive_a(1'b0, '0, '0);
        step();
        step();

        // ReqA held for 6 cycles: 3 writes, never two strobes in a row.
        drive_a(1'b1, 5'd12, 32'h0C0C0C0C);
        cnt = 0; consec = 0; prev_ld = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (dec_ld === 1'b1) cnt++;
            if (dec_ld === 1'b1 && prev_ld) consec++;
            prev_ld = (dec_ld === 1'b1);
        end
        chk("held_writes", 64'(cnt),    64'(3));
        chk("held_consec", 64'(consec), 64'(0));
        drive_a(1'b0, '0, '0);
        step();

        // Random traffic obeying the hold-until-ack protocol.
        for (int i = 0; i < 400; i++) begin
            if (m_ack_a) begin
                if ($urandom_range(0, 1) == 1) drive_a(1'b1, rand_addr(), $urandom());
                else                           drive_a(1'b0, addr_a, data_a);
            end else if (!req_a && $urandom_range(0, 2) == 0) begin
                drive_a(1'b1, rand_addr(), $urandom());
            end
            if (m_ack_b) begin
                if ($urandom_range(0, 1) == 1) drive_b(1'b1, rand_addr(), $urandom());
                else                           drive_b(1'b0, addr_b, data_b);
            end else if (!req_b && $urandom_range(0, 2) == 0) begin
                drive_b(1'b1, rand_addr(), $urandom());
            end
            if (i == 200) do_reset();
            step();
        end
        drive_a(1'b0, '0, '0);
        drive_b(1'b0, '0, '0);
        repeat (3) step();

        do_reset();
        step();
        chk("final_idle_ld", 64'(dec_ld), 64'(0));
        chk("sb_drained", 64'(exp_q.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_write_sched.md
# regfile_write_sched

Write-port scheduler for the SPARC register file. Two writeback sources (ALU port A, load/memory port B) share the single register-file write path. The block arbitrates round-robin and registers the winner's destination and data. For one cycle it drives the 5x32 decoder's input and load enable, plus the shared write-data bus, and acknowledges the source. Writes to register 0 (%g0, hardwired zero) are acknowledged but never loaded.

## Interface

Parameters:
- ADDR_W, 5, register address width; decoder input width.
- DATA_W, 32, write-data width.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- ReqA  in  1  port A write request; level, held until AckA.
- AddrA  in  ADDR_W  port A destination register.
- DataA  in  DATA_W  port A write data.
- AckA  out  1  one-cycle grant/complete pulse to port A.
- ReqB  in  1  port B write request; level, held until AckB.
- AddrB  in  ADDR_W  port B destination register.
- DataB  in  DATA_W  port B write data.
- AckB  out  1  one-cycle grant/complete pulse to port B.
- DecIn  out  ADDR_W  to decoder address input.
- DecLd  out  1  to decoder load enable; one-hot write strobe enable.
- WrData  out  DATA_W  shared register-file write data.
- Busy  out  1  high while in WRITE.

## Operation

- FSM states: IDLE, WRITE.
- IDLE:
  - If ReqA or ReqB is high at a rising edge, select a winner and capture its Addr/Data into output registers.
  - Set Ack of the winner, set DecLd, and go to WRITE.
  - With no request, stay in IDLE.
- WRITE:
  - Outputs are held for exactly one cycle; next state is always IDLE.
  - Requests arriving while in WRITE are ignored until IDLE.
- Arbitration: a 1-bit pointer `last` records the last granted port.
  - Only one port requesting: that port wins.
  - Both requesting: the port not equal to `last` wins.
  - `last` updates on every grant.
- Register 0: if the captured address is 0, DecLd stays 0 during WRITE. The Ack still pulses and DecIn/WrData are still captured.
- A requester must drop Req (or present a new transaction) at the edge that ends its Ack cycle. Req still high in the following IDLE cycle counts as a new request.
- Outputs in IDLE:
  - DecLd = 0 and AckA = AckB = 0.
  - DecIn and WrData hold their last values; they are not cleared.
- Maximum throughput is one write per 2 cycles.

## Timing

- Reset value of every output is 0: AckA, AckB, DecIn, DecLd, WrData, Busy. Reset also sets state = IDLE and `last` = B, so A wins the first tie.
- Latency: Req high at edge k leads to DecLd/DecIn/WrData/Ack/Busy valid from edge k to edge k+1. The register file latches at edge k+1.
- All outputs are registered; no combinational path from Req/Addr/Data to any output.
- Both requests at edge k: the winner is serviced during k..k+1. The loser, still requesting, is sampled at edge k+2 and serviced during k+2..k+3.
- A request deasserted before the sampling edge is never serviced; no partial grant.
- Reset asserted during WRITE: outputs clear immediately (async). No Ack is delivered, so the requester keeps Req and is re-serviced after reset release.
- Reset deasserted: the first sampling edge is the first rising Clk with Reset low.

## Structure

- Shared package (sparc_glue_pkg):
  - state encoding localparams ST_IDLE, ST_WRITE.
  - port ids PORT_A = 0, PORT_B = 1.
  - REG_G0 = 5'b00000.
- One sub-module, rr_pick_2: inputs ReqA, ReqB, `last`; outputs a grant-valid flag and the winning port id. Purely combinational, used in the IDLE transition.
- The top level holds the FSM, the `last` pointer, and the output registers. It connects to the existing Decoder_5x32 through DecIn/DecLd, with no changes to the decoder.

## Test plan

- Reset check: Reset high mid-simulation, then check all outputs and Busy are 0. Release Reset, then check no DecLd before the first request.
- Single A request: ReqA=1, AddrA=5'd7, DataA=32'hDEADBEEF at edge k. Expect exactly one cycle of DecIn=7, DecLd=1, WrData=DEADBEEF, AckA=1, Busy=1, then IDLE.
- Simultaneous requests after reset: AddrA=3, AddrB=9, both held. Expect A served first (DecIn=3), then B two cycles later (DecIn=9). A repeated tie alternates A, B, A, B.
- %g0 drop: ReqB=1, AddrB=0, DataB=32'h12345678. Expect AckB pulse, Busy=1, DecLd=0 throughout.
- Reset in WRITE: assert Reset during A's WRITE cycle. Expect DecLd/AckA to go to 0 immediately. After release with ReqA held, expect a full re-service.
- Held request: keep ReqA high for 6 cycles with a constant address. Expect DecLd pulses every other cycle (3 writes) and DecLd never high on two consecutive cycles.
